// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word with a
// valid/ready handshake and streams it out one bit per clock with framing flags.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_frame_start;
  logic             r_last_bit;

  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_is_last;

  // The bit on ser_out always sits at the outgoing end of r_shift, so the
  // next bit to send is its neighbour one position inward.
  assign w_first_bit    = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign w_next_bit     = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
  assign w_shifted      = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};
  assign w_next_is_last = (r_cnt == CW'(WIDTH - 2));

  assign load_ready = !rst && ((r_state == IDLE) || r_last_bit);
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_last_bit    <= 1'b0;
    end else if (w_accept) begin
      r_state       <= SHIFT;
      r_shift       <= data_in;
      r_cnt         <= '0;
      r_ser_out     <= w_first_bit;
      r_ser_valid   <= 1'b1;
      r_frame_start <= 1'b1;
      r_last_bit    <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_last_bit) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_last_bit    <= 1'b0;
          end else begin
            r_shift       <= w_shifted;
            r_cnt         <= r_cnt + CW'(1);
            r_ser_out     <= w_next_bit;
            r_frame_start <= 1'b0;
            r_last_bit    <= w_next_is_last;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign last_bit    = r_last_bit;
  assign busy        = r_ser_valid;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  data_in holds a word to transmit.
REQ-007 load_ready  output  1  block accepts a word at this edge.
REQ-008 ser_out  output  1  serial data bit, registered.
REQ-009 ser_valid  output  1  ser_out carries a frame bit, registered.
REQ-010 frame_start  output  1  high during the first bit of a frame, registered.
REQ-011 last_bit  output  1  high during the final bit of a frame, registered.
REQ-012 busy  output  1  high while a frame is being shifted (equals ser_valid).

Function
REQ-013 FSM SHALL have two states: IDLE and SHIFT.
REQ-014 Accept SHALL occur at a rising edge where load_valid=1, load_ready=1 and rst=0; data_in is captured into an internal WIDTH-bit shift register at that edge.
REQ-015 load_ready SHALL be combinational: 1 when state=IDLE, or state=SHIFT with last_bit=1; 0 otherwise, and 0 while rst=1.
REQ-016 Latency: the first bit SHALL appear on ser_out in the cycle immediately after the accept edge, with ser_valid=1 and frame_start=1.
REQ-017 A frame SHALL occupy exactly WIDTH consecutive cycles with ser_valid=1; frame_start=1 only in cycle 0, last_bit=1 only in cycle WIDTH-1.
REQ-018 Bit order: MSB_FIRST=1 sends data_in[WIDTH-1] down to data_in[0]; MSB_FIRST=0 sends data_in[0] up to data_in[WIDTH-1].
REQ-019 A bit counter of ceil(log2(WIDTH)) bits SHALL count 0..WIDTH-1 within a frame and reset to 0 on each accept; it SHALL not wrap within a frame.
REQ-020 Transition IDLE->SHIFT on accept; SHIFT->SHIFT on accept in the last-bit cycle (back-to-back, no gap cycle); SHIFT->IDLE at end of last-bit cycle with no accept.
REQ-021 Back-to-back: the cycle after the last bit of frame N SHALL carry bit 0 of frame N+1 with frame_start=1.
REQ-022 In IDLE: ser_valid=0, ser_out=0, frame_start=0, last_bit=0.
REQ-023 load_valid during SHIFT outside the last-bit cycle SHALL be ignored; data_in changes mid-frame SHALL not affect the frame in flight.
REQ-024 WIDTH=2 SHALL work with frame_start and last_bit in adjacent cycles.

Reset
REQ-025 On a rising edge with rst=1: state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, frame_start=0, last_bit=0, busy=0.
REQ-026 rst SHALL take priority over load_valid at the same edge; no word is accepted.
REQ-027 rst during SHIFT SHALL abort the frame; remaining bits are discarded and never transmitted.
REQ-028 After rst deasserts, load_ready SHALL be 1 in the first cycle and an accept at the next edge SHALL be legal.

Verification
REQ-029 Reset: rst=1 for 2 edges with load_valid=1, data_in=4'b1111 -> all outputs 0, no frame started.
REQ-030 Single frame, MSB_FIRST=1: accept 4'b1010 -> ser_out 1,0,1,0 over 4 cycles, frame_start in cycle 1, last_bit in cycle 4, then ser_valid=0.
REQ-031 Back-to-back: load_valid held, 4'b1100 then 4'b0110 -> ser_out 1,1,0,0,0,1,1,0 with no gap; load_ready=1 only in the last-bit cycles after the first accept.
REQ-032 Ignore mid-frame: during frame 4'b1010, set data_in=4'b0101 with load_valid=1 in cycle 2 -> stream unchanged 1,0,1,0; load_ready=0 in cycles 1-3.
REQ-033 Abort: accept 4'b1001, assert rst in cycle 2 -> ser_valid=0 from the next cycle; a new accept of 4'b0011 sends 0,0,1,1.
REQ-034 LSB-first: MSB_FIRST=0, accept 4'b1000 -> ser_out 0,0,0,1.
